spi_frame_receiver: RTL and testbench

Parametrised SPI-slave frame receiver that replaces the separate SPI byte slave and RGBW data dispenser of the lamp controller. It oversamples SCK/CS/MOSI in the system clock domain, assembles a fixed-length frame of NUM_CH data words plus one checksum word, and commits the words atomically to a double-buffered output bus only when the frame is complete and the checksum is correct. Its outputs feed the colour/PWM path; a malformed frame leaves the outputs untouched.

---
 rtl/spi_frame_receiver.sv | 156 +++++++++++++++
 tb/tb_spi_frame_receiver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_receiver.sv
// SPI-slave frame receiver: oversampled pins, shadow word buffer,
// atomic commit of a complete, checksum-verified frame.
`timescale 1ns/1ps
module spi_frame_receiver #(
   parameter int NUM_CH   = 7,
   parameter int DATA_W   = 8,
   parameter int CKSUM_EN = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sck,
   input  logic                     cs,
   input  logic                     mosi,
   output logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic                     frame_valid,
   output logic                     frame_err,
   output logic                     rx_busy
);

   localparam int FRAME_WORDS = NUM_CH + ((CKSUM_EN != 0) ? 1 : 0);
   localparam int WCW = $clog2(FRAME_WORDS + 1);
   localparam int BCW = $clog2(DATA_W);
   localparam logic [WCW-1:0] WC_FULL = WCW'(FRAME_WORDS);
   localparam logic [WCW-1:0] WC_DATA = WCW'(NUM_CH);
   localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, RECV, EVAL} state_t;

   state_t state, state_nxt;

   logic sck_s1, sck_s2, sck_d;
   logic cs_s1, cs_s2, cs_d;
   logic mosi_s1, mosi_s2;
   logic sck_rise, cs_fall, cs_rise;

   logic [DATA_W-1:0]        shift_reg;
   logic [DATA_W-1:0]        word;
   logic [BCW-1:0]           bit_cnt;
   logic [WCW-1:0]           word_cnt;
   logic [NUM_CH*DATA_W-1:0] shadow;
   logic [DATA_W-1:0]        rx_cksum;
   logic [DATA_W-1:0]        run_cksum;
   logic                     overflow;
   logic                     accept;

   // Sync flops reset to 0 so a cs held low across reset is not a start.
   always_ff @(posedge clk) begin
      if (reset) begin
         sck_s1  <= 1'b0;
         sck_s2  <= 1'b0;
         sck_d   <= 1'b0;
         cs_s1   <= 1'b0;
         cs_s2   <= 1'b0;
         cs_d    <= 1'b0;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         sck_s1  <= sck;
         sck_s2  <= sck_s1;
         sck_d   <= sck_s2;
         cs_s1   <= cs;
         cs_s2   <= cs_s1;
         cs_d    <= cs_s2;
         mosi_s1 <= mosi;
         mosi_s2 <= mosi_s1;
      end
   end

   assign sck_rise = sck_s2 & ~sck_d;
   assign cs_fall  = ~cs_s2 & cs_d;
   assign cs_rise  = cs_s2 & ~cs_d;

   assign word = {shift_reg[DATA_W-2:0], mosi_s2};

   assign accept = (bit_cnt == '0) && (word_cnt == WC_FULL) &&
                   !overflow &&
                   ((CKSUM_EN == 0) || (rx_cksum == run_cksum));

   assign rx_busy = (state == RECV);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (cs_fall) state_nxt = RECV;
         RECV:    if (cs_rise) state_nxt = EVAL;
         EVAL:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shift_reg   <= '0;
         bit_cnt     <= '0;
         word_cnt    <= '0;
         shadow      <= '0;
         rx_cksum    <= '0;
         run_cksum   <= '0;
         overflow    <= 1'b0;
         ch_data     <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         case (state)
            IDLE: begin
               shift_reg <= '0;
               bit_cnt   <= '0;
               word_cnt  <= '0;
               run_cksum <= '0;
               overflow  <= 1'b0;
            end
            RECV: begin
               if (sck_rise) begin
                  shift_reg <= word;
                  if (bit_cnt == BC_LAST) begin
                     bit_cnt <= '0;
                     if (word_cnt < WC_DATA) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                           if (word_cnt == WCW'(k))
                              shadow[k*DATA_W +: DATA_W] <= word;
                        end
                        run_cksum <= run_cksum + word;
                     end else if ((CKSUM_EN != 0) &&
                                  (word_cnt == WC_DATA)) begin
                        rx_cksum <= word;
                     end else begin
                        overflow <= 1'b1;
                     end
                     if (word_cnt != WC_FULL)
                        word_cnt <= word_cnt + 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            EVAL: begin
               if (accept) begin
                  ch_data     <= shadow;
                  frame_valid <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Scoreboard bench: two receivers share sck/mosi, each with its own cs.
`timescale 1ns/1ps
module tb_spi_frame_receiver;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sck = 1'b0;
   logic        mosi = 1'b0;
   logic        cs1 = 1'b1;
   logic        cs2 = 1'b1;
   logic [55:0] ch1;
   logic        fv1, fe1, busy1;
   logic [47:0] ch2;
   logic        fv2, fe2, busy2;

   always #5 clk = ~clk;

   spi_frame_receiver #(
      .NUM_CH(7), .DATA_W(8), .CKSUM_EN(1)
   ) u_dut1 (
      .clk(clk), .reset(reset), .sck(sck), .cs(cs1), .mosi(mosi),
      .ch_data(ch1), .frame_valid(fv1), .frame_err(fe1),
      .rx_busy(busy1)
   );

   spi_frame_receiver #(
      .NUM_CH(4), .DATA_W(12), .CKSUM_EN(0)
   ) u_dut2 (
      .clk(clk), .reset(reset), .sck(sck), .cs(cs2), .mosi(mosi),
      .ch_data(ch2), .frame_valid(fv2), .frame_err(fe2),
      .rx_busy(busy2)
   );

   typedef struct {
      logic        err;
      logic [63:0] data;
   } exp_t;

   exp_t        q1[$];
   exp_t        q2[$];
   exp_t        e1, e2;
   logic [15:0] words[$];
   logic [63:0] model1 = '0;
   logic [63:0] model2 = '0;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitor: every output pulse consumes one expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (fv1 || fe1) begin
            if (q1.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL dut1_unexpected: fv=%b fe=%b want none",
                        fv1, fe1);
            end else begin
               e1 = q1.pop_front();
               chk("dut1_frame", {6'd0, fv1, fe1, ch1},
                   {6'd0, !e1.err, e1.err, e1.data[55:0]});
            end
         end
         if (fv2 || fe2) begin
            if (q2.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL dut2_unexpected: fv=%b fe=%b want none",
                        fv2, fe2);
            end else begin
               e2 = q2.pop_front();
               chk("dut2_frame", {14'd0, fv2, fe2, ch2},
                   {14'd0, !e2.err, e2.err, e2.data[47:0]});
            end
         end
      end
   end

   task automatic wait_clk(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int half(bit jit);
      return jit ? int'($urandom_range(3, 6)) : 4;
   endfunction

   task automatic send_word(logic [15:0] w, int width, bit jit);
      for (int i = width - 1; i >= 0; i--) begin
         mosi = w[i];
         wait_clk(half(jit));
         sck = 1'b1;
         wait_clk(half(jit));
         sck = 1'b0;
      end
   endtask

   task automatic push(bit sel, bit err, logic [63:0] data);
      exp_t e;
      e.err = err;
      if (sel) begin
         e.data = err ? model2 : data;
         if (!err) model2 = data;
         q2.push_back(e);
      end else begin
         e.data = err ? model1 : data;
         if (!err) model1 = data;
         q1.push_back(e);
      end
   endtask

   task automatic run_frame(bit sel, int width, bit jit, int gap,
                            int tail_bits);
      if (sel) cs2 = 1'b0;
      else     cs1 = 1'b0;
      wait_clk(4);
      chk("busy_in_frame", {63'd0, sel ? busy2 : busy1}, 64'd1);
      foreach (words[i]) send_word(words[i], width, jit);
      if (tail_bits > 0) send_word(16'h5, tail_bits, jit);
      wait_clk(2);
      if (sel) cs2 = 1'b1;
      else     cs1 = 1'b1;
      wait_clk(gap);
      chk("busy_after", {63'd0, sel ? busy2 : busy1}, 64'd0);
   endtask

   initial begin
      wait_clk(4);
      chk("reset_ch1", {8'd0, ch1}, 64'd0);
      chk("reset_ch2", {16'd0, ch2}, 64'd0);
      chk("reset_flags", {58'd0, fv1, fe1, busy1, fv2, fe2, busy2},
          64'd0);
      reset = 1'b0;
      wait_clk(6);

      words = '{16'h01, 16'h02, 16'h03, 16'h04,
                16'h05, 16'h06, 16'h07, 16'h1C};
      push(0, 0, 64'h07060504030201);
      run_frame(0, 8, 0, 10, 0);

      words = '{16'h01, 16'h02, 16'h03, 16'h04,
                16'h05, 16'h06, 16'h07, 16'h1D};
      push(0, 1, 64'd0);
      run_frame(0, 8, 0, 10, 0);

      words = '{16'h01, 16'h02, 16'h03, 16'h04,
                16'h05, 16'h06, 16'h15};
      push(0, 1, 64'd0);
      run_frame(0, 8, 0, 10, 0);

      words = '{16'h01, 16'h02, 16'h03, 16'h04, 16'h05,
                16'h06, 16'h07, 16'h1C, 16'h00};
      push(0, 1, 64'd0);
      run_frame(0, 8, 0, 10, 0);

      words = '{16'h01, 16'h02, 16'h03, 16'h04,
                16'h05, 16'h06, 16'h07, 16'h1C};
      push(0, 1, 64'd0);
      run_frame(0, 8, 0, 10, 3);

      // Reset in the middle of a frame: no pulse, outputs cleared.
      cs1 = 1'b0;
      wait_clk(4);
      for (int i = 1; i <= 4; i++) send_word(16'(i), 8, 0);
      reset = 1'b1;
      wait_clk(3);
      reset = 1'b0;
      model1 = '0;
      for (int i = 5; i <= 7; i++) send_word(16'(i), 8, 0);
      send_word(16'h1C, 8, 0);
      wait_clk(2);
      cs1 = 1'b1;
      wait_clk(12);
      chk("reset_mid_ch1", {8'd0, ch1}, 64'd0);
      chk("reset_mid_busy", {63'd0, busy1}, 64'd0);

      words = '{16'h10, 16'h20, 16'h30, 16'h40,
                16'h50, 16'h60, 16'h70, 16'hC0};
      push(0, 0, 64'h70605040302010);
      run_frame(0, 8, 0, 10, 0);

      words = '{16'hAA, 16'hAA, 16'hAA, 16'hAA,
                16'hAA, 16'hAA, 16'hAA, 16'hA6};
      push(0, 0, 64'hAAAAAAAAAAAAAA);
      run_frame(0, 8, 0, 4, 0);

      words = '{16'h55, 16'h55, 16'h55, 16'h55,
                16'h55, 16'h55, 16'h55, 16'h53};
      push(0, 0, 64'h55555555555555);
      run_frame(0, 8, 0, 10, 0);

      words = '{16'h123, 16'h456, 16'h789, 16'hABC};
      push(1, 0, 64'hABC789456123);
      run_frame(1, 12, 0, 10, 0);
      push(1, 0, 64'hABC789456123);
      run_frame(1, 12, 1, 10, 0);

      words = '{16'hFFF, 16'h000, 16'h800, 16'h001};
      push(1, 0, 64'h001800000FFF);
      run_frame(1, 12, 1, 10, 0);

      for (int i = 0; i < 50; i++) begin
         if (q1.size() == 0 && q2.size() == 0) break;
         wait_clk(1);
      end
      chk("dut1_pending", 64'(q1.size()), 64'd0);
      chk("dut2_pending", 64'(q2.size()), 64'd0);
      wait_clk(10);
      chk("final_ch1", {8'd0, ch1}, 64'h55555555555555);
      chk("final_ch2", {16'd0, ch2}, 64'h001800000FFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
